// File: rtl/subtrator_serial_param.sv
// subtrator_serial_param: multi-cycle serial subtractor, S = A - B - Bin.
// Processes CHUNK bits per clock with a registered borrow between chunks.
// Input side is a valid/ready slave; output side is a valid/ready master.
// Build option: define SUBTRATOR_SAT_EN for unsigned saturation (S forced
// to zero when the final borrow is set); otherwise S wraps modulo 2^WIDTH.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid, in_ready  operand handshake (A, B, Bin)
//   A, B                WIDTH-bit minuend / subtrahend
//   Bin                 borrow in
//   out_valid, out_ready result handshake
//   S                   WIDTH-bit difference
//   Bout                borrow out of the MSB
//   Z                   final S is zero (after any saturation)
//   V                   signed overflow of the raw difference
//
// Constraints: WIDTH >= 2, WIDTH an integer multiple of CHUNK.
module subtrator_serial_param #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Bout,
  output logic             Z,
  output logic             V
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned DIFF_W = CHUNK + 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             borrow_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] s_q;
  logic             bout_q;
  logic             z_q;
  logic             v_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [31:0]       shamt_c;
  logic [CHUNK-1:0]  a_chunk_c;
  logic [CHUNK-1:0]  b_chunk_c;
  logic [DIFF_W-1:0] diff_c;
  logic              borrow_d;
  logic [WIDTH-1:0]  s_d;
  logic [WIDTH-1:0]  s_fin_d;
  logic              z_d;
  logic              v_d;

  // Current chunk subtraction and the result word with that chunk merged in.
  always_comb begin
    shamt_c   = 32'(cnt_q) * CHUNK;
    a_chunk_c = CHUNK'(a_q >> shamt_c);
    b_chunk_c = CHUNK'(b_q >> shamt_c);
    // Extra top bit of the widened difference is the chunk borrow-out.
    diff_c    = {1'b0, a_chunk_c} - {1'b0, b_chunk_c} - DIFF_W'(borrow_q);
    borrow_d  = diff_c[CHUNK];
    s_d       = (s_q & ~(CHUNK_MASK << shamt_c))
              | (WIDTH'(diff_c[CHUNK-1:0]) << shamt_c);
`ifdef SUBTRATOR_SAT_EN
    s_fin_d   = borrow_d ? '0 : s_d;
`else
    s_fin_d   = s_d;
`endif
    z_d       = (s_fin_d == '0);
    // Overflow always judged on the raw (unsaturated) difference.
    v_d       = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (s_d[WIDTH-1] != a_q[WIDTH-1]);
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
      s_q         <= '0;
      bout_q      <= 1'b0;
      z_q         <= 1'b0;
      v_q         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= A;
            b_q        <= B;
            borrow_q   <= Bin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          borrow_q <= borrow_d;
          if (cnt_q == CNT_LAST) begin
            s_q         <= s_fin_d;
            bout_q      <= borrow_d;
            z_q         <= z_d;
            v_q         <= v_d;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            s_q   <= s_d;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign S         = s_q;
  assign Bout      = bout_q;
  assign Z         = z_q;
  assign V         = v_q;

endmodule

// File: tb/tb_subtrator_serial_param.sv
// Self-checking bench for subtrator_serial_param (WIDTH=16, CHUNK=4):
// directed literal cases, backpressure, mid-operation reset, then random traffic
// checked every cycle against a transaction-level reference model.
module tb_subtrator_serial_param;

  localparam int unsigned W = 16;
  localparam int unsigned C = 4;
  localparam int unsigned N = W / C;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] S;
  logic         Bout;
  logic         Z;
  logic         V;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  subtrator_serial_param #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Bout      (Bout),
    .Z         (Z),
    .V         (V)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Reference arithmetic from plain integer math.
  task automatic model_calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                            output logic [W-1:0] s, output logic bo,
                            output logic z, output logic v);
    int ud;
    int sd;
    ud = int'(a) - int'(b) - int'(bi);
    sd = int'($signed(a)) - int'($signed(b)) - int'(bi);
    bo = (ud < 0);
    s  = W'(ud);
`ifdef SUBTRATOR_SAT_EN
    if (bo) s = '0;
`endif
    z  = (s == '0);
    v  = (sd > 32767) || (sd < -32768);
  endtask

  // Transaction-level model: accept, N-cycle countdown, hold until taken.
  bit           m_busy  = 1'b0;
  bit           m_valid = 1'b0;
  int           m_left  = 0;
  logic [W-1:0] m_s = '0;
  logic         m_b = 1'b0;
  logic         m_z = 1'b0;
  logic         m_v = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_left  = 0;
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid = 1'b0;
        m_busy  = 1'b0;
      end
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) m_valid = 1'b1;
    end else if (in_valid) begin
      m_busy = 1'b1;
      m_left = N;
      model_calc(A, B, Bin, m_s, m_b, m_z, m_v);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, !m_busy);
      chk("out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("S", S, m_s);
        chk("Bout", Bout, m_b);
        chk("Z", Z, m_z);
        chk("V", V, m_v);
      end
    end else begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_S", S, 0);
      chk("rst_flags", {Bout, Z, V}, 0);
    end
  end

  // Called at a negedge; returns cycles from accepting edge to out_valid.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                      output int lat);
    int g;
    A = a; B = b; Bin = bi; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 100) begin @(negedge clk); g++; end
    if (g >= 100) chk("accept_timeout", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    chk("out_valid_seen", out_valid, 1);
  endtask

  task automatic expect_res(input string name, input logic [W-1:0] s, input logic bo,
                            input logic z, input logic v);
    chk({name, "_S"}, S, s);
    chk({name, "_Bout"}, Bout, bo);
    chk({name, "_Z"}, Z, z);
    chk({name, "_V"}, V, v);
  endtask

  initial begin
    int lat;
    int g;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);

    send(16'h1234, 16'h0234, 1'b0, lat);
    chk("lat_1234", lat, N);
    expect_res("t1234", 16'h1000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    send(16'h0000, 16'h0001, 1'b0, lat);
    chk("lat_0001", lat, N);
`ifdef SUBTRATOR_SAT_EN
    expect_res("t0m1", 16'h0000, 1'b1, 1'b1, 1'b0);
`else
    expect_res("t0m1", 16'hFFFF, 1'b1, 1'b0, 1'b0);
`endif
    @(negedge clk);

    send(16'h8000, 16'h0001, 1'b0, lat);
    expect_res("t8000", 16'h7FFF, 1'b0, 1'b0, 1'b1);
    @(negedge clk);

    send(16'h0100, 16'h00FF, 1'b1, lat);
    expect_res("tchain", 16'h0000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);

    send(16'h5A5A, 16'h5A5A, 1'b0, lat);
    expect_res("teq", 16'h0000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);

    // Backpressure: stall 5 cycles in DONE with in_valid held high.
    out_ready = 1'b0;
    A = 16'h5555; B = 16'h1111; Bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    g = 0;
    while (!out_valid && g < 100) begin @(negedge clk); g++; end
    chk("bp_lat", g, N);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", in_ready, 0);
      expect_res("bp_hold", 16'h4444, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_ready", in_ready, 1);
    chk("bp_idle_valid", out_valid, 0);
    A = 16'h0003; B = 16'h0005;
    @(negedge clk);
    chk("bp_new_accept", in_ready, 0);
    in_valid = 1'b0;
    g = 0;
    while (!out_valid && g < 100) begin @(negedge clk); g++; end
`ifdef SUBTRATOR_SAT_EN
    expect_res("bp_next", 16'h0000, 1'b1, 1'b1, 1'b0);
`else
    expect_res("bp_next", 16'hFFFE, 1'b1, 1'b0, 1'b0);
`endif
    @(negedge clk);

    // Reset during the second RUN cycle.
    A = 16'hABCD; B = 16'h1234; Bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_S", S, 0);
    chk("mid_rst_flags", {Bout, Z, V}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", out_valid, 0);
    end
    send(16'hFFFF, 16'h0001, 1'b1, lat);
    chk("lat_post_rst", lat, N);
    expect_res("post_rst", 16'hFFFD, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Random traffic, including in_valid while busy and random backpressure.
    for (int i = 0; i < 2000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      A         = W'($urandom());
      B         = ($urandom_range(0, 7) == 0) ? A : W'($urandom());
      Bin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
